// File: rtl/axi_light_arbiter.sv
// Round-robin arbiter that shares one AXI-light slave port among N_MASTERS masters.
// Only one transaction is in flight; AW/W/B or AR/R are routed to the grantee only.
module axi_light_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic [N_MASTERS-1:0]            m_awvalid,
  output logic [N_MASTERS-1:0]            m_awready,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_awaddr,
  input  logic [N_MASTERS-1:0]            m_wvalid,
  output logic [N_MASTERS-1:0]            m_wready,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  output logic [N_MASTERS-1:0]            m_bvalid,
  input  logic [N_MASTERS-1:0]            m_bready,
  input  logic [N_MASTERS-1:0]            m_arvalid,
  output logic [N_MASTERS-1:0]            m_arready,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_araddr,
  output logic [N_MASTERS-1:0]            m_rvalid,
  input  logic [N_MASTERS-1:0]            m_rready,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            s_awvalid,
  input  logic                            s_awready,
  output logic [ADDR_W-1:0]               s_awaddr,
  output logic                            s_wvalid,
  input  logic                            s_wready,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic                            s_bvalid,
  output logic                            s_bready,
  output logic                            s_arvalid,
  input  logic                            s_arready,
  output logic [ADDR_W-1:0]               s_araddr,
  input  logic                            s_rvalid,
  output logic                            s_rready,
  input  logic [DATA_W-1:0]               s_rdata,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_READ    = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  state_t              state_r;
  state_t              route_state_s;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [ID_W-1:0]     grant_id_r;
  logic                busy_r;
  logic                aw_done_r;
  logic                w_done_r;
  logic [N_MASTERS-1:0] req_s;
  logic [ID_W:0]       pick_s;
  logic [ID_W-1:0]     winner_s;
  logic                found_s;
  logic                aw_hs_s;
  logic                w_hs_s;
  logic                b_hs_s;
  logic                ar_hs_s;
  logic                r_hs_s;

  // Returns {found, index}: first requester after ptr, wrapping modulo N_MASTERS.
  function automatic logic [ID_W:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                            input logic [ID_W-1:0]      ptr);
    logic [ID_W:0]   result;
    logic [ID_W-1:0] sel;
    int              idx;
    result = {(ID_W+1){1'b0}};
    // Walk from the farthest offset down so the nearest requester is written last.
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_MASTERS;
      sel = ID_W'(idx);
      if (req[sel]) begin
        result = {1'b1, sel};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  assign req_s    = m_awvalid | m_arvalid;
  assign pick_s   = rr_pick(req_s, rr_ptr_r);
  assign found_s  = pick_s[ID_W];
  assign winner_s = pick_s[ID_W-1:0];

  // Reset forces the routing view to IDLE so every valid/ready is low while res is high.
  assign route_state_s = res ? ST_IDLE : state_r;

  assign s_awaddr = m_awaddr[grant_id_r*ADDR_W +: ADDR_W];
  assign s_araddr = m_araddr[grant_id_r*ADDR_W +: ADDR_W];
  assign s_wdata  = m_wdata[grant_id_r*DATA_W +: DATA_W];
  assign s_wstrb  = m_wstrb[grant_id_r*STRB_W +: STRB_W];
  assign m_rdata  = s_rdata;

  assign aw_hs_s = s_awvalid & s_awready;
  assign w_hs_s  = s_wvalid & s_wready;
  assign b_hs_s  = s_bvalid & s_bready;
  assign ar_hs_s = s_arvalid & s_arready;
  assign r_hs_s  = s_rvalid & s_rready;

  assign grant_id = grant_id_r;
  assign busy     = busy_r;

  // Handshake routing between the granted master and the slave port.
  always_comb begin
    m_awready = {N_MASTERS{1'b0}};
    m_wready  = {N_MASTERS{1'b0}};
    m_bvalid  = {N_MASTERS{1'b0}};
    m_arready = {N_MASTERS{1'b0}};
    m_rvalid  = {N_MASTERS{1'b0}};
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    case (route_state_s)
      ST_WRITE: begin
        s_awvalid             = m_awvalid[grant_id_r] & ~aw_done_r;
        m_awready[grant_id_r] = s_awready & ~aw_done_r;
        s_wvalid              = m_wvalid[grant_id_r] & ~w_done_r;
        m_wready[grant_id_r]  = s_wready & ~w_done_r;
      end
      ST_WR_RESP: begin
        m_bvalid[grant_id_r] = s_bvalid;
        s_bready             = m_bready[grant_id_r];
      end
      ST_READ: begin
        s_arvalid             = m_arvalid[grant_id_r];
        m_arready[grant_id_r] = s_arready;
      end
      ST_RD_RESP: begin
        m_rvalid[grant_id_r] = s_rvalid;
        s_rready             = m_rready[grant_id_r];
      end
      default: begin
        s_awvalid = 1'b0;
      end
    endcase
  end

  // Transaction sequencer: grant, address/data phases, response, back to IDLE.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= ID_W'(N_MASTERS - 1);
      grant_id_r <= {ID_W{1'b0}};
      busy_r     <= 1'b0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_id_r <= winner_s;
            rr_ptr_r   <= winner_s;
            busy_r     <= 1'b1;
            state_r    <= m_awvalid[winner_s] ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          // AW and W may finish in either order or together; leave once both are done.
          if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            state_r   <= ST_WR_RESP;
          end else begin
            aw_done_r <= aw_done_r | aw_hs_s;
            w_done_r  <= w_done_r | w_hs_s;
          end
        end
        ST_WR_RESP: begin
          if (b_hs_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (ar_hs_s) begin
            state_r <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (r_hs_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_light_arbiter.md
Name: axi_light_arbiter

Overview:
- Shares one AXI-light slave port (the memory controller's priority input) between N_MASTERS AXI-light masters: the controller plus future nodes.
- Single outstanding transaction system-wide; round-robin grant; the full transaction (address, data, response) is routed to the granted master.
- Sits between the masters' if_axi_light master ports and memory_controller, replacing the direct controller-to-memory connection.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8)
ID_W, 1, width of grant index, = clog2(N_MASTERS), min 1
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width DATA_W/8

Ports:
clk  in  1  system clock
res  in  1  synchronous active-high reset
m_awvalid/m_awready  in/out  N_MASTERS  per-master write-address handshake
m_awaddr  in  N_MASTERS*ADDR_W  per-master write address, master i at slice i
m_wvalid/m_wready  in/out  N_MASTERS  per-master write-data handshake
m_wdata  in  N_MASTERS*DATA_W  write data
m_wstrb  in  N_MASTERS*DATA_W/8  write strobes
m_bvalid/m_bready  out/in  N_MASTERS  write response handshake
m_arvalid/m_arready  in/out  N_MASTERS  read-address handshake
m_araddr  in  N_MASTERS*ADDR_W  read address
m_rvalid/m_rready  out/in  N_MASTERS  read-data handshake
m_rdata  out  DATA_W  read data, broadcast; qualified by m_rvalid
s_*  mirrored single-width slave-side signals: s_awvalid, s_awready, s_awaddr, s_wvalid, s_wready, s_wdata, s_wstrb, s_bvalid, s_bready, s_arvalid, s_arready, s_araddr, s_rvalid, s_rready, s_rdata
grant_id  out  ID_W  index of current or last granted master
busy  out  1  high while a transaction is owned

Behaviour:
- One clock clk; reset res is synchronous and active-high.
- Reset: state=IDLE, rr_ptr=N_MASTERS-1, grant_id=0, busy=0, aw_done=w_done=0. All ready/valid outputs on both sides are 0 during reset and in IDLE.
- Request i = m_awvalid[i] | m_arvalid[i].
- IDLE:
  - Search i = rr_ptr+1 .. rr_ptr+N_MASTERS (mod N_MASTERS); the first requester wins.
  - Register grant_id=winner, rr_ptr=winner, busy=1.
  - Next state WRITE if m_awvalid[winner], else READ. A write beats a read when a master asserts both.
  - No requester: remain in IDLE.
- WRITE:
  - AW and W channels of the granted master are passed through combinationally to s_*; all other masters see ready=0.
  - AW handshake (s_awvalid&s_awready) sets aw_done; once set, s_awvalid is forced 0.
  - W channel is treated the same way via w_done.
  - Both handshakes may complete in the same cycle or in either order.
  - When aw_done&w_done, go to WR_RESP and clear both flags.
- WR_RESP: s_bvalid is routed to m_bvalid[grant_id]; m_bready[grant_id] is routed to s_bready. On the handshake go to IDLE with busy=0.
- READ: AR is routed the same way. On the AR handshake go to RD_RESP.
- RD_RESP: route s_rvalid/s_rdata to the grantee and its m_rready to s_rready. On the handshake go to IDLE with busy=0.
- Latency:
  - Request sampled in IDLE at cycle t; s_awvalid/s_arvalid are visible at t+1.
  - After the response handshake at cycle u, the next grant is registered at u+1 and its valid is visible at u+2 (one IDLE bubble).
- Fairness: rr_ptr advances only on a grant. A master that keeps requesting waits at most N_MASTERS-1 transactions.
- Mid-transaction events:
  - A master dropping valid mid-transaction is a protocol violation; the arbiter keeps waiting with no timeout.
  - A grantee asserting arvalid during WRITE is ignored until a later grant.
- Reset mid-transaction: the next cycle is IDLE with all valids/readies 0. No response is delivered to the former grantee.
- Slave signals s_*addr/s_*data are muxed from grant_id in every state (don't-care while the valid is 0).

Test Plan:
- Reset with master0 awvalid held high -> all m_*ready=0, s_awvalid=0, busy=0, grant_id=0 throughout reset; first grant to master0 the cycle after res falls.
- Master1 alone writes 0xDEADBEEF to 0x100, slave AW ready delayed 3 cycles, W ready immediate -> w_done first, s_awaddr=0x100, s_wdata=0xDEADBEEF; m_bvalid[1] only; busy drops the cycle after the B handshake.
- Masters 0 and 1 both request continuously, 4 transactions -> grant order 0,1,0,1; one IDLE cycle between each response and the next s_*valid.
- Master0 asserts awvalid and arvalid together -> write completes first; read granted only after master1's pending request is served (N_MASTERS=2).
- Read by master1 from 0x200, slave returns 0x12345678 with m_rready[1] low 2 cycles -> s_rready mirrors m_rready[1]; m_rvalid[0] stays 0; state holds RD_RESP until the handshake.
- res asserted in WR_RESP with s_bvalid high -> next cycle busy=0, m_bvalid all 0, s_bready=0; after release, a new request is granted normally with rr_ptr reset to N_MASTERS-1.
